// File: rtl/sram_multiport.sv
// Multi-port word-addressed SRAM with per-port byte-lane writes and a fixed-latency,
// fully pipelined read path. Reads are read-first against same-cycle writes.
module sram_multiport #(
    parameter int NUM_WORDS  = 1024,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_PORTS  = 2,
    parameter int LATENCY    = 1,
    localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int BE        = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_PORTS-1:0]                  req_i,
    input  logic [NUM_PORTS-1:0]                  we_i,
    input  logic [NUM_PORTS-1:0][AW-1:0]          addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_PORTS-1:0][BE-1:0]          be_i,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_PORTS-1:0]                  rvalid_o
);

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic [NUM_PORTS-1:0] in_range;
    logic [NUM_PORTS-1:0] wr_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_ctl
            assign in_range[gi] = (int'(addr_i[gi]) < NUM_WORDS);
            // Reset is folded in here so the array itself never sees rst_i.
            assign wr_en[gi]    = req_i[gi] & we_i[gi] & in_range[gi] & ~rst_i;
        end
    endgenerate

    // Later ports overwrite earlier ones on the same lane, so the highest index wins.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < BE; b++) begin
                if (wr_en[p] && be_i[p][b]) begin
                    mem[addr_i[p]][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[p][b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rd_pipe
            logic                  rd_valid_d;
            logic [DATA_WIDTH-1:0] rd_data_d;
            logic [LATENCY-1:0]    vld_q;
            logic [DATA_WIDTH-1:0] dat_q [LATENCY];

            // Sampled before this edge's writes land, giving read-first behaviour.
            always_comb begin
                rd_valid_d = req_i[gi] & ~we_i[gi];
                rd_data_d  = '0;
                if (in_range[gi]) begin
                    rd_data_d = mem[addr_i[gi]];
                end
            end

            // Data stages only load on a valid token, so the last stage holds between reads.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int k = 0; k < LATENCY; k++) begin
                        dat_q[k] <= '0;
                    end
                end else begin
                    vld_q[0] <= rd_valid_d;
                    if (rd_valid_d) begin
                        dat_q[0] <= rd_data_d;
                    end
                    for (int k = 1; k < LATENCY; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        if (vld_q[k-1]) begin
                            dat_q[k] <= dat_q[k-1];
                        end
                    end
                end
            end

            assign rvalid_o[gi] = vld_q[LATENCY-1];
            assign rdata_o[gi]  = dat_q[LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_sram_multiport.sv
// Directed bench: a 3-port latency-1 instance driven from a vector table, and a
// 12-word latency-3 instance exercised by hand-written pipeline/reset/range sequences.
module tb_sram_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- instance A: 3 ports, 1024 words, latency 1 ----------------
    logic                  rst_a;
    logic [2:0]            req_a, we_a, rvalid_a;
    logic [2:0][9:0]       addr_a;
    logic [2:0][63:0]      wdata_a, rdata_a;
    logic [2:0][7:0]       be_a;

    sram_multiport #(.NUM_WORDS(1024), .DATA_WIDTH(64), .BYTE_WIDTH(8), .NUM_PORTS(3), .LATENCY(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .be_i(be_a), .rdata_o(rdata_a), .rvalid_o(rvalid_a)
    );

    // ---------------- instance B: 1 port, 12 words, latency 3 ----------------
    logic                  rst_b;
    logic [0:0]            req_b, we_b, rvalid_b;
    logic [0:0][3:0]       addr_b;
    logic [0:0][63:0]      wdata_b, rdata_b;
    logic [0:0][7:0]       be_b;

    sram_multiport #(.NUM_WORDS(12), .DATA_WIDTH(64), .BYTE_WIDTH(8), .NUM_PORTS(1), .LATENCY(3)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .be_i(be_b), .rdata_o(rdata_b), .rvalid_o(rvalid_b)
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [9:0]  addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } op_t;

    typedef struct packed {
        op_t [2:0]        op;
        logic [2:0]       ev;
        logic [2:0][63:0] ed;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic op_t nop();
        op_t o;
        o = '0;
        return o;
    endfunction

    function automatic op_t wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] b);
        op_t o;
        o.req = 1'b1; o.we = 1'b1; o.addr = a; o.wdata = d; o.be = b;
        return o;
    endfunction

    function automatic op_t rd(input logic [9:0] a);
        op_t o;
        o.req = 1'b1; o.we = 1'b0; o.addr = a; o.wdata = 64'hDEAD_BEEF_DEAD_BEEF; o.be = 8'hA5;
        return o;
    endfunction

    function automatic op_t idle_op(input logic w, input logic [9:0] a);
        op_t o;
        o.req = 1'b0; o.we = w; o.addr = a; o.wdata = '0; o.be = 8'hFF;
        return o;
    endfunction

    task automatic set_row(input int i, input op_t o0, input op_t o1, input op_t o2,
                           input logic [2:0] ev, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2);
        vecs[i].op[0] = o0; vecs[i].op[1] = o1; vecs[i].op[2] = o2;
        vecs[i].ev    = ev;
        vecs[i].ed[0] = d0; vecs[i].ed[1] = d1; vecs[i].ed[2] = d2;
    endtask

    task automatic b_drive(input logic r, input logic w, input logic [3:0] a, input logic [63:0] d);
        req_b[0] = r; we_b[0] = w; addr_b[0] = a; wdata_b[0] = d; be_b[0] = 8'hFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pre_b(input int a);
        return (a < 4) ? 64'h10 + 64'(a) : 64'h100 + 64'(a);
    endfunction

    localparam logic [63:0] VA = 64'h1122334455667788;
    localparam logic [63:0] VP = 64'h11223344AAAAAAAA;
    localparam logic [63:0] VF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] VK = 64'h0123456789ABCDEF;
    localparam logic [63:0] VL = 64'h2222333333331111;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_row(0,  wr(5, VA, 8'hFF), nop(), nop(),                       3'b000, 64'h0, 64'h0, 64'h0);
        set_row(1,  nop(), rd(5), nop(),                                  3'b010, 64'h0, VA, 64'h0);
        set_row(2,  wr(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F), nop(), nop(),     3'b000, 64'h0, VA, 64'h0);
        set_row(3,  rd(5), nop(), nop(),                                  3'b001, VP, VA, 64'h0);
        set_row(4,  nop(), nop(), wr(9, VK, 8'hFF),                       3'b000, VP, VA, 64'h0);
        set_row(5,  wr(9, 64'h0, 8'hFF), wr(9, VF, 8'hFF), rd(9),         3'b100, VP, VA, VK);
        set_row(6,  rd(9), nop(), nop(),                                  3'b001, VF, VA, VK);
        set_row(7,  wr(20, 64'h1111111111111111, 8'hFF), wr(20, 64'h2222222222222222, 8'hF0),
                    wr(20, 64'h3333333333333333, 8'h3C),                  3'b000, VF, VA, VK);
        set_row(8,  nop(), rd(20), nop(),                                 3'b010, VF, VL, VK);
        set_row(9,  rd(5), nop(), rd(20),                                 3'b101, VP, VL, VL);
        set_row(10, rd(9), nop(), nop(),                                  3'b001, VF, VL, VL);
        set_row(11, rd(20), rd(9), nop(),                                 3'b011, VL, VF, VL);
        set_row(12, idle_op(1'b1, 5), idle_op(1'b0, 9), nop(),            3'b000, VL, VF, VL);
        set_row(13, rd(5), nop(), nop(),                                  3'b001, VP, VF, VL);

        rst_a = 1'b1; rst_b = 1'b1;
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; be_a = '0;
        b_drive(1'b0, 1'b0, 4'd0, 64'h0);
        #2;
        chk("a_reset_rvalid", 64'(rvalid_a), 64'h0);
        for (int p = 0; p < 3; p++) chk($sformatf("a_reset_rdata%0d", p), rdata_a[p], 64'h0);
        chk("b_reset_rvalid", 64'(rvalid_b), 64'h0);
        chk("b_reset_rdata", rdata_b[0], 64'h0);
        step();
        step();
        rst_a = 1'b0; rst_b = 1'b0;

        // table-driven vectors on instance A
        for (int i = 0; i < NVEC; i++) begin
            for (int p = 0; p < 3; p++) begin
                req_a[p]   = vecs[i].op[p].req;
                we_a[p]    = vecs[i].op[p].we;
                addr_a[p]  = vecs[i].op[p].addr;
                wdata_a[p] = vecs[i].op[p].wdata;
                be_a[p]    = vecs[i].op[p].be;
            end
            step();
            $display("row %0d: rvalid=%b rdata0=%h rdata1=%h rdata2=%h", i, rvalid_a,
                     rdata_a[0], rdata_a[1], rdata_a[2]);
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("row%0d_rvalid%0d", i, p), 64'(rvalid_a[p]), 64'(vecs[i].ev[p]));
                chk($sformatf("row%0d_rdata%0d", i, p), rdata_a[p], vecs[i].ed[p]);
            end
        end
        req_a = '0;

        // instance B: preload all words
        for (int a = 0; a < 12; a++) begin
            b_drive(1'b1, 1'b1, 4'(a), pre_b(a));
            step();
            chk($sformatf("b_preload%0d_rvalid", a), 64'(rvalid_b), 64'h0);
        end

        // back-to-back latency-3 reads of addrs 0..3
        for (int c = 0; c < 7; c++) begin
            if (c < 4) b_drive(1'b1, 1'b0, 4'(c), 64'h0);
            else       b_drive(1'b0, 1'b0, 4'd0, 64'h0);
            step();
            $display("b pipe cycle %0d: rvalid=%b rdata=%h", c, rvalid_b[0], rdata_b[0]);
            chk($sformatf("b_pipe%0d_rvalid", c), 64'(rvalid_b), (c >= 2 && c <= 5) ? 64'h1 : 64'h0);
            chk($sformatf("b_pipe%0d_rdata", c), rdata_b[0],
                (c < 2) ? 64'h0 : (c <= 5) ? pre_b(c - 2) : pre_b(3));
        end

        // read in flight, then reset mid-pipeline with a write presented during reset
        b_drive(1'b1, 1'b0, 4'd5, 64'h0);
        step();
        b_drive(1'b1, 1'b1, 4'd6, 64'hDEAD);
        #2;
        rst_b = 1'b1;
        #1;
        $display("b async reset: rvalid=%b rdata=%h", rvalid_b[0], rdata_b[0]);
        chk("b_async_rst_rvalid", 64'(rvalid_b), 64'h0);
        chk("b_async_rst_rdata", rdata_b[0], 64'h0);
        step();
        step();
        #1;
        rst_b = 1'b0;
        b_drive(1'b0, 1'b0, 4'd0, 64'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("b_post_rst%0d_rvalid", c), 64'(rvalid_b), 64'h0);
        end

        // write during reset must have been dropped
        for (int c = 0; c < 3; c++) begin
            if (c == 0) b_drive(1'b1, 1'b0, 4'd6, 64'h0);
            else        b_drive(1'b0, 1'b0, 4'd0, 64'h0);
            step();
            chk($sformatf("b_rd6_%0d_rvalid", c), 64'(rvalid_b), (c == 2) ? 64'h1 : 64'h0);
        end
        chk("b_rd6_rdata", rdata_b[0], pre_b(6));

        // out-of-range read returns zero with valid
        for (int c = 0; c < 3; c++) begin
            if (c == 0) b_drive(1'b1, 1'b0, 4'd13, 64'h0);
            else        b_drive(1'b0, 1'b0, 4'd0, 64'h0);
            step();
            chk($sformatf("b_rd13_%0d_rvalid", c), 64'(rvalid_b), (c == 2) ? 64'h1 : 64'h0);
        end
        $display("b read addr 13: rdata=%h", rdata_b[0]);
        chk("b_rd13_rdata", rdata_b[0], 64'h0);

        // out-of-range write must leave every word unchanged
        b_drive(1'b1, 1'b1, 4'd13, VF);
        step();
        for (int c = 0; c < 14; c++) begin
            if (c < 12) b_drive(1'b1, 1'b0, 4'(c), 64'h0);
            else        b_drive(1'b0, 1'b0, 4'd0, 64'h0);
            step();
            if (c >= 2) begin
                $display("b scan addr %0d: rvalid=%b rdata=%h", c - 2, rvalid_b[0], rdata_b[0]);
                chk($sformatf("b_scan%0d_rvalid", c - 2), 64'(rvalid_b), 64'h1);
                chk($sformatf("b_scan%0d_rdata", c - 2), rdata_b[0], pre_b(c - 2));
            end
        end
        b_drive(1'b0, 1'b0, 4'd0, 64'h0);
        step();
        chk("b_final_rvalid", 64'(rvalid_b), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
